fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Shares one FIFO write port among `NUM_REQ` convolution producers (per-channel event emitters) using round-robin arbitration with packet locking. Multi-word events are never interleaved. The block sits between the convolution channel units and the producer side of an event FIFO. It drives `write_en`/`write_data` and obeys the FIFO's `full` flag, so overflow is impossible by construction.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: word width; must match the FIFO.
- `IDX_W`, `$clog2(NUM_REQ)`: requester index width; derived, do not override.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has a word.
- `req_last` in NUM_REQ: word of requester i is the final word of its packet.
- `req_data` in NUM_REQ×DATA_WIDTH: packed array, one word per requester.
- `req_ready` out NUM_REQ: one-hot or zero; transfer for i when `req_valid[i] & req_ready[i]`.
- `full` in 1: FIFO full flag.
- `write_en` out 1: FIFO write strobe.
- `write_data` out DATA_WIDTH: word written.
- `grant_id` out IDX_W: index of current or last winner.
- `locked` out 1: high while a packet is in progress (state BURST).

## Operation
- FSM states are ARB and BURST. Registers:
  - `state`
  - `rr_ptr` (IDX_W)
  - `owner` (IDX_W)
- Reset values:
  - `state`=ARB, `rr_ptr`=0, `owner`=0.
  - While `rst`=1, `req_ready`=0 and `write_en`=0 regardless of inputs.
- Reset outputs after release, with no requests: `grant_id`=0, `locked`=0, `write_data`=0.
- ARB state:
  - If `full`=0 and any `req_valid`, winner w is the first valid index scanning `rr_ptr`, `rr_ptr+1`, … wrapping at NUM_REQ−1→0.
  - `req_ready[w]`=1 and the transfer occurs this cycle.
  - If `req_last[w]`: `rr_ptr`←(w+1) mod NUM_REQ and the FSM stays in ARB.
  - Otherwise: `owner`←w and the FSM goes to BURST.
- BURST state:
  - Only `owner` is eligible; `req_ready[owner]`=~`full`.
  - The owner dropping `req_valid` holds the lock; no transfer occurs and others stay blocked.
  - A transfer with `req_last` sets `rr_ptr`←(owner+1) mod NUM_REQ and returns to ARB.
- `write_en` = |(`req_valid` & `req_ready`); `write_data` = `req_data[winner]` when `write_en`, else 0.
- `full`=1: all `req_ready`=0 and no state change.
- Wrap: `rr_ptr` at NUM_REQ−1 with `last` goes to 0. Non-power-of-two NUM_REQ uses explicit modulo, never bit truncation.
- Simultaneous requests: exactly one grant per cycle; the others wait with no data loss.
- `rst` asserted mid-BURST: the lock is abandoned and the FSM returns to ARB on the next edge. Requesters must restart their packet.

## Timing
- Zero-latency, combinational path from `req_valid`/`full` to `req_ready` and `write_en`. Ready is combinationally dependent on valid, so requesters must not wait for ready before raising valid.
- Throughput: one word per cycle while `full`=0.
- `full` is sampled the same cycle as the write. This relies on the FIFO asserting `full` combinationally or registering it so that a write in cycle t with one slot free raises `full` by cycle t+1.
- `grant_id`/`locked` update at the edge following a transfer.

## Configuration
- `FIFO_ARB_STATS_EN` defined adds:
  - input `stats_clr` (1);
  - output `stat_words` (NUM_REQ×16), saturating per-requester count of words transferred;
  - output `stat_stall` (16), saturating count of cycles with any `req_valid` and `full`=1.
- Counters reset to 0 on `rst` or `stats_clr`. If `stats_clr` coincides with a count event, clear wins.
- `FIFO_ARB_STATS_EN` undefined: the ports and counters are absent. Arbitration behaviour is identical in both builds.

## Structure
- `fifo_arb_pkg`: `arb_state_t` enum {ARB, BURST} and the `STAT_W`=16 constant.
- Sub-module `rr_priority_pick`:
  - Purely combinational.
  - Inputs: request vector and start pointer.
  - Outputs: one-hot grant, winner index, and `any` flag.

## Test plan
- NUM_REQ=4, all valid with `last`=1 continuously, `full`=0 → grants 0,1,2,3,0,… one per cycle; `write_data` matches the winner's word each cycle.
- Requester 2 sends 3-word packet {0xA0,0xA1,0xA2 last} while 0,1,3 are valid → FIFO receives A0,A1,A2 contiguously; `locked`=1 for 2 cycles; next grant goes to 3.
- Mid-BURST owner drops valid for 2 cycles → no writes and no grants to others; resumes with the remaining word.
- `full`=1 for 5 cycles with all valid → `write_en`=0, `req_ready`=0. With stats enabled, `stat_stall` increments by 5.
- `rst` pulsed during BURST → next cycle ARB, `rr_ptr`=0, `locked`=0; first grant goes to the lowest valid index.
- Stats build: 70000 words from requester 1 → `stat_words[1]`=0xFFFF (saturated); `stats_clr` returns it to 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// Optional statistics counters are enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    // Explicit wrap so non-power-of-two requester counts never rely on truncation.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after `start`, wrapping.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int cand;

    // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(start) + k;
            if (cand >= N) cand = cand - N;
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand[IW-1:0];
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin FIFO write-port arbiter with packet locking for multi-word events.
// Define FIFO_ARB_STATS_EN to add per-requester word counters and a stall counter.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_last,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                full,
    output logic                                write_en,
    output logic [DATA_WIDTH-1:0]               write_data,
    output logic [IDX_W-1:0]                    grant_id,
`ifdef FIFO_ARB_STATS_EN
    input  logic                                stats_clr,
    output logic [NUM_REQ-1:0][STAT_W-1:0]      stat_words,
    output logic [STAT_W-1:0]                   stat_stall,
`endif
    output logic                                locked
);

    arb_state_t        state, next_state;
    logic [IDX_W-1:0]  rr_ptr, next_rr_ptr;
    logic [IDX_W-1:0]  owner, next_owner;
    logic [IDX_W-1:0]  winner;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .start (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        next_state  = state;
        next_rr_ptr = rr_ptr;
        next_owner  = owner;
        winner      = pick_idx;
        req_ready   = '0;
        if (!rst && !full) begin
            unique case (state)
                ARB: begin
                    if (pick_any) begin
                        req_ready = pick_grant;
                        if (req_last[pick_idx]) begin
                            next_rr_ptr = IDX_W'(wrap_inc(int'(pick_idx), NUM_REQ));
                        end else begin
                            next_owner = pick_idx;
                            next_state = BURST;
                        end
                    end
                end
                BURST: begin
                    // The lock holds even while the owner idles; others stay blocked.
                    winner            = owner;
                    req_ready[owner]  = 1'b1;
                    if (req_valid[owner] && req_last[owner]) begin
                        next_rr_ptr = IDX_W'(wrap_inc(int'(owner), NUM_REQ));
                        next_state  = ARB;
                    end
                end
                default: next_state = ARB;
            endcase
        end
    end

    assign write_en   = |(req_valid & req_ready);
    assign write_data = write_en ? req_data[winner] : '0;
    assign locked     = (state == BURST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            rr_ptr   <= '0;
            owner    <= '0;
            grant_id <= '0;
        end else begin
            state  <= next_state;
            rr_ptr <= next_rr_ptr;
            owner  <= next_owner;
            if (write_en) grant_id <= winner;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && stat_words[i] != '1)
                    stat_words[i] <= stat_words[i] + 1'b1;
            end
            if (|req_valid && full && stat_stall != '1)
                stat_stall <= stat_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: expected FIFO words go to a scoreboard queue.
// Statistics checks are included when FIFO_ARB_STATS_EN is defined.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_last;
    logic [N-1:0][DW-1:0] req_data;
    logic [N-1:0]         req_ready;
    logic                 full;
    logic                 write_en;
    logic [DW-1:0]        write_data;
    logic [IW-1:0]        grant_id;
    logic                 locked;
`ifdef FIFO_ARB_STATS_EN
    logic                 stats_clr;
    logic [N-1:0][15:0]   stat_words;
    logic [15:0]          stat_stall;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .full       (full),
        .write_en   (write_en),
        .write_data (write_data),
        .grant_id   (grant_id),
`ifdef FIFO_ARB_STATS_EN
        .stats_clr  (stats_clr),
        .stat_words (stat_words),
        .stat_stall (stat_stall),
`endif
        .locked     (locked)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic default_data();
        for (int i = 0; i < N; i++) req_data[i] = DW'(8'h10 + i);
    endtask

    // One cycle: sample at the falling edge, pop the scoreboard on a write, then cross the rising edge.
    task automatic tick(input string tag, input logic [N-1:0] exp_ready);
        logic [DW-1:0] exp_word;
        @(negedge clk);
        check({tag, "/ready"}, 32'(req_ready), 32'(exp_ready));
        check({tag, "/write_en"}, 32'(write_en), 32'(|(exp_ready & req_valid)));
        if (write_en) begin
            if (exp_q.size() == 0) begin
                check({tag, "/unexpected_write"}, 32'(write_data), 32'hFFFF_FFFF);
            end else begin
                exp_word = exp_q.pop_front();
                check({tag, "/write_data"}, 32'(write_data), 32'(exp_word));
            end
        end else begin
            check({tag, "/idle_data"}, 32'(write_data), 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        full      = 1'b0;
        req_valid = '1;
        req_last  = '1;
        default_data();
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        @(posedge clk);
        #1;
        tick("reset_hold", 4'b0000);

        rst       = 1'b0;
        req_valid = '0;
        tick("post_reset_idle", 4'b0000);
        check("reset_grant_id", 32'(grant_id), 32'h0);
        check("reset_locked", 32'(locked), 32'h0);

        // All valid, single-word packets: strict rotation 0,1,2,3,0,...
        req_valid = '1;
        req_last  = '1;
        for (int c = 0; c < 8; c++) begin
            exp_q.push_back(DW'(8'h10 + (c % N)));
            tick("rotate", N'(1) << (c % N));
        end
        check("rotate_grant_id", 32'(grant_id), 32'h3);

        // Move the pointer to 2, then requester 2 sends A0,A1,A2 while everyone else waits.
        req_valid = 4'b0010;
        exp_q.push_back(8'h11);
        tick("solo1", 4'b0010);
        req_valid   = '1;
        req_last    = 4'b1011;
        req_data[2] = 8'hA0;
        exp_q.push_back(8'hA0);
        tick("pkt_a0", 4'b0100);
        check("pkt_locked1", 32'(locked), 32'h1);
        check("pkt_grant_id", 32'(grant_id), 32'h2);
        req_data[2] = 8'hA1;
        exp_q.push_back(8'hA1);
        tick("pkt_a1", 4'b0100);
        check("pkt_locked2", 32'(locked), 32'h1);
        req_data[2] = 8'hA2;
        req_last    = '1;
        exp_q.push_back(8'hA2);
        tick("pkt_a2", 4'b0100);
        check("pkt_unlocked", 32'(locked), 32'h0);
        default_data();
        exp_q.push_back(8'h13);
        tick("after_pkt", 4'b1000);

        // Requester 0 opens a packet, idles two cycles holding the lock, then finishes.
        req_last    = 4'b1110;
        req_data[0] = 8'hB0;
        exp_q.push_back(8'hB0);
        tick("gap_b0", 4'b0001);
        req_valid = 4'b1110;
        tick("gap_idle1", 4'b0001);
        tick("gap_idle2", 4'b0001);
        check("gap_locked", 32'(locked), 32'h1);
        req_valid   = '1;
        req_last    = '1;
        req_data[0] = 8'hB1;
        exp_q.push_back(8'hB1);
        tick("gap_b1", 4'b0001);
        default_data();
        exp_q.push_back(8'h11);
        tick("after_gap", 4'b0010);

        // FIFO full for five cycles: nothing moves, then the pending winner (2) goes.
        full = 1'b1;
        for (int c = 0; c < 5; c++) tick("full", 4'b0000);
        full = 1'b0;
        exp_q.push_back(8'h12);
        tick("after_full", 4'b0100);
`ifdef FIFO_ARB_STATS_EN
        check("stat_stall", 32'(stat_stall), 32'd5);
`endif

        // Reset in the middle of a packet from requester 3.
        req_last    = 4'b0111;
        req_data[3] = 8'hC0;
        exp_q.push_back(8'hC0);
        tick("rst_c0", 4'b1000);
        check("rst_pre_locked", 32'(locked), 32'h1);
        rst = 1'b1;
        tick("rst_mid_burst", 4'b0000);
        rst       = 1'b0;
        req_valid = 4'b0110;
        req_last  = '1;
        default_data();
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        exp_q.push_back(8'h11);
        tick("rst_first_grant", 4'b0010);
        check("rst_next_grant_id", 32'(grant_id), 32'h1);

`ifdef FIFO_ARB_STATS_EN
        // Clear coinciding with a transfer from requester 1: clear must win.
        req_valid = 4'b0010;
        stats_clr = 1'b1;
        exp_q.push_back(8'h11);
        tick("clr_wins", 4'b0010);
        stats_clr = 1'b0;
        check("clr_wins_words1", 32'(stat_words[1]), 32'h0);
        repeat (70000) @(posedge clk);
        #1;
        check("sat_words1", 32'(stat_words[1]), 32'hFFFF);
        check("sat_words0", 32'(stat_words[0]), 32'h0);
        req_valid = '0;
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        check("clr_words1", 32'(stat_words[1]), 32'h0);
        check("clr_stall", 32'(stat_stall), 32'h0);
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
